// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
//
// Round-robin arbiter for an AHB multi-manager interconnect. It shares one
// address/data path between MANAGERS requesters. A grant is held across
// burst beats and locked sequences. The grant can only move at a transfer
// boundary, which is an edge with HREADY high and HTRANS equal to IDLE or
// NONSEQ.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   resetn     : synchronous active-low reset
//   requestV   : per-manager bus request (level)
//   lockV      : per-manager locked-transfer request, qualified by requestV
//   htrans     : HTRANS of the granted manager, taken from the address mux
//   hready     : bus HREADY; the address phase completes when it is high
//   grantedV   : one-hot address-phase grant (registered)
//   grantedD   : one-hot data-phase owner (registered)
//   owner      : binary index of grantedV
//   hmastlock  : HMASTLOCK for the current address phase (registered)
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
  parameter int MANAGERS = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [MANAGERS-1:0]         requestV,
  input  logic [MANAGERS-1:0]         lockV,
  input  logic [1:0]                  htrans,
  input  logic                        hready,
  output logic [MANAGERS-1:0]         grantedV,
  output logic [MANAGERS-1:0]         grantedD,
  output logic [$clog2(MANAGERS)-1:0] owner,
  output logic                        hmastlock
);

  localparam int OW = $clog2(MANAGERS);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [MANAGERS-1:0] GRANT_RESET = {{(MANAGERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_PARKED = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Round-robin search starting one past the current owner; the owner itself
  // is visited last, so it only wins if nobody else is requesting.
  function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0]       cur,
                                            input logic [MANAGERS-1:0] req);
    logic [OW-1:0] win;
    logic [OW-1:0] idx;
    logic          found;
    win   = cur;
    found = 1'b0;
    for (int k = 1; k <= MANAGERS; k++) begin
      idx = OW'((int'(cur) + k) % MANAGERS);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

  // One-hot to binary; the grant vector is one-hot by construction.
  function automatic logic [OW-1:0] onehot_enc(input logic [MANAGERS-1:0] v);
    logic [OW-1:0] idx;
    idx = {OW{1'b0}};
    for (int i = 0; i < MANAGERS; i++) begin
      idx = idx | (v[i] ? OW'(i) : {OW{1'b0}});
    end
    return idx;
  endfunction

  function automatic logic [MANAGERS-1:0] onehot_dec(input logic [OW-1:0] idx);
    return GRANT_RESET << idx;
  endfunction

  state_e              state_q,     state_d;
  logic [MANAGERS-1:0] grant_v_q,   grant_v_d;
  logic [MANAGERS-1:0] grant_d_q,   grant_d_d;
  logic [HW-1:0]       hold_cnt_q,  hold_cnt_d;
  logic                hmastlock_q, hmastlock_d;

  logic [OW-1:0] owner_s;
  logic [OW-1:0] win_s;
  logic          boundary_s;
  logic          beat_s;
  logic          any_req_s;
  logic          others_req_s;
  logic          arb_s;
  logic          stay_locked_s;

  assign owner_s      = onehot_enc(grant_v_q);
  assign boundary_s   = hready && ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ));
  assign beat_s       = hready && htrans[1];
  assign any_req_s    = |requestV;
  assign others_req_s = |(requestV & ~grant_v_q);

  // Next-state, grant and beat-counter computation; hready low freezes all.
  always_comb begin
    state_d       = state_q;
    grant_v_d     = grant_v_q;
    grant_d_d     = grant_d_q;
    hold_cnt_d    = hold_cnt_q;
    hmastlock_d   = hmastlock_q;
    win_s         = owner_s;
    arb_s         = 1'b0;
    stay_locked_s = (state_q == ST_LOCKED) && lockV[owner_s] && requestV[owner_s];

    if (hready) begin
      grant_d_d = grant_v_q;

      if (beat_s && (hold_cnt_q < HW'(MAX_HOLD))) begin
        hold_cnt_d = hold_cnt_q + HW'(1'b1);
      end else begin
        hold_cnt_d = hold_cnt_q;
      end

      if (!boundary_s || stay_locked_s) begin
        state_d = state_q;
      end else if (!any_req_s) begin
        // Grant parks on whoever holds it now.
        state_d = ST_PARKED;
      end else begin
        case (state_q)
          ST_PARKED: arb_s = 1'b1;
          ST_ACTIVE: arb_s = !requestV[owner_s] ||
                             ((hold_cnt_q == HW'(MAX_HOLD)) && others_req_s);
          // Leaving a locked sequence always runs a full search, so a
          // waiting manager gets the bus even if the old owner still requests.
          ST_LOCKED: arb_s = 1'b1;
          default:   arb_s = 1'b1;
        endcase

        if (arb_s) begin
          win_s = rr_pick(owner_s, requestV);
        end else begin
          win_s = owner_s;
        end

        if (win_s != owner_s) begin
          grant_v_d  = onehot_dec(win_s);
          hold_cnt_d = {HW{1'b0}};
        end else begin
          grant_v_d  = grant_v_q;
        end

        if (requestV[win_s] && lockV[win_s]) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_ACTIVE;
        end
      end

      hmastlock_d = (state_d == ST_LOCKED);
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_PARKED;
      grant_v_q   <= GRANT_RESET;
      grant_d_q   <= GRANT_RESET;
      hold_cnt_q  <= {HW{1'b0}};
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_v_q   <= grant_v_d;
      grant_d_q   <= grant_d_d;
      hold_cnt_q  <= hold_cnt_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign grantedV  = grant_v_q;
  assign grantedD  = grant_d_q;
  assign owner     = owner_s;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_rr_arbiter
//
// Table-driven bench for ahb_rr_arbiter (MANAGERS=4, MAX_HOLD=4). Each record
// holds the inputs applied before a rising edge and the outputs expected
// after it. Expected values are queued when the stimulus is driven and
// popped when the outputs are sampled 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_ahb_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] S = 2'b11;

  typedef struct {
    logic       rstn;
    logic       hr;
    logic [1:0] ht;
    logic [3:0] req;
    logic [3:0] lk;
    logic [3:0] gv;
    logic [3:0] gd;
    logic       ml;
  } vec_t;

  typedef struct {
    logic [3:0] gv;
    logic [3:0] gd;
    logic       ml;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] requestV;
  logic [3:0] lockV;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] grantedV;
  logic [3:0] grantedD;
  logic [1:0] owner;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  ahb_rr_arbiter #(.MANAGERS(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .requestV  (requestV),
    .lockV     (lockV),
    .htrans    (htrans),
    .hready    (hready),
    .grantedV  (grantedV),
    .grantedD  (grantedD),
    .owner     (owner),
    .hmastlock (hmastlock)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] v);
    case (v)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'bxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rstn, input logic hr, input logic [1:0] ht,
                     input logic [3:0] req, input logic [3:0] lk,
                     input logic [3:0] gv, input logic [3:0] gd, input logic ml);
    vec_t v;
    v.rstn = rstn; v.hr = hr; v.ht = ht; v.req = req; v.lk = lk;
    v.gv = gv; v.gd = gd; v.ml = ml;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    resetn   = v.rstn;
    hready   = v.hr;
    htrans   = v.ht;
    requestV = v.req;
    lockV    = v.lk;
    e.gv = v.gv; e.gd = v.gd; e.ml = v.ml;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " grantedV"},  32'(grantedV),  32'(e.gv));
    check({tag, " grantedD"},  32'(grantedD),  32'(e.gd));
    check({tag, " owner"},     32'(owner),     32'(enc(e.gv)));
    check({tag, " hmastlock"}, 32'(hmastlock), 32'(e.ml));
    check({tag, " onehotV"},   32'($onehot(grantedV)), 32'(1));
    check({tag, " onehotD"},   32'($onehot(grantedD)), 32'(1));
  endtask

  initial begin
    vec_t h;
    resetn = 1'b0; hready = 1'b1; htrans = I; requestV = 4'b0000; lockV = 4'b0000;

    //   rstn  hr    ht  req      lock     gv       gd       ml
    add(1'b0, 1'b1, I,  4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0); // reset
    for (int k = 0; k < 5; k++)
      add(1'b1, 1'b1, I, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0); // parked idle
    // rotation on request drops
    add(1'b1, 1'b1, I,  4'b1110, 4'b0000, 4'b0010, 4'b0001, 1'b0);
    add(1'b1, 1'b1, I,  4'b1100, 4'b0000, 4'b0100, 4'b0010, 1'b0);
    add(1'b1, 1'b1, I,  4'b1000, 4'b0000, 4'b1000, 4'b0100, 1'b0);
    add(1'b1, 1'b1, I,  4'b0010, 4'b0000, 4'b0010, 4'b1000, 1'b0);
    // burst: NONSEQ + 3 SEQ while manager 3 waits, drop during SEQ
    add(1'b1, 1'b1, NS, 4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, S,  4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, S,  4'b1010, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, S,  4'b1000, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    add(1'b1, 1'b1, I,  4'b1000, 4'b0000, 4'b1000, 4'b0010, 1'b0);
    // hold limit with manager 0 issuing single NONSEQ beats
    add(1'b1, 1'b1, I,  4'b0001, 4'b0000, 4'b0001, 4'b1000, 1'b0);
    for (int k = 0; k < 4; k++)
      add(1'b1, 1'b1, NS, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    add(1'b1, 1'b1, NS, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 1'b0); // limit hit
    add(1'b1, 1'b1, NS, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 1'b0); // counter cleared
    // locked sequence by manager 2
    add(1'b1, 1'b1, I,  4'b0100, 4'b0100, 4'b0100, 4'b0010, 1'b1);
    for (int k = 0; k < 6; k++)
      add(1'b1, 1'b1, NS, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    add(1'b1, 1'b1, S,  4'b1111, 4'b0000, 4'b0100, 4'b0100, 1'b1);
    add(1'b1, 1'b1, I,  4'b1111, 4'b0000, 4'b1000, 4'b0100, 1'b0); // lock exit
    // hready low freezes while requests change
    add(1'b1, 1'b0, I,  4'b0001, 4'b0000, 4'b1000, 4'b0100, 1'b0);
    add(1'b1, 1'b0, NS, 4'b0101, 4'b0000, 4'b1000, 4'b0100, 1'b0);
    add(1'b1, 1'b0, I,  4'b0001, 4'b0000, 4'b1000, 4'b0100, 1'b0);
    add(1'b1, 1'b1, I,  4'b0001, 4'b0000, 4'b0001, 4'b1000, 1'b0);
    // reset in the middle of a lock
    add(1'b1, 1'b1, I,  4'b0010, 4'b0010, 4'b0010, 4'b0001, 1'b1);
    add(1'b1, 1'b1, NS, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1'b1);
    add(1'b0, 1'b1, S,  4'b0010, 4'b0010, 4'b0001, 4'b0001, 1'b0);
    add(1'b1, 1'b1, I,  4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Hand sequence: a request pulse at a BUSY beat is never granted, then a
    // held request is granted and a frozen cycle keeps grantedD behind.
    h = '{rstn: 1'b1, hr: 1'b1, ht: B,  req: 4'b0100, lk: 4'b0000, gv: 4'b0001, gd: 4'b0001, ml: 1'b0};
    apply(h, "busy_pulse");
    h = '{rstn: 1'b1, hr: 1'b1, ht: I,  req: 4'b0000, lk: 4'b0000, gv: 4'b0001, gd: 4'b0001, ml: 1'b0};
    apply(h, "pulse_gone");
    h = '{rstn: 1'b1, hr: 1'b1, ht: I,  req: 4'b0100, lk: 4'b0000, gv: 4'b0100, gd: 4'b0001, ml: 1'b0};
    apply(h, "held_req");
    h = '{rstn: 1'b1, hr: 1'b0, ht: NS, req: 4'b0000, lk: 4'b0000, gv: 4'b0100, gd: 4'b0001, ml: 1'b0};
    apply(h, "stall");
    h = '{rstn: 1'b1, hr: 1'b1, ht: I,  req: 4'b0000, lk: 4'b0000, gv: 4'b0100, gd: 4'b0100, ml: 1'b0};
    apply(h, "park_last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
